pipe_ctrl_unit: RTL and testbench

Parametrised pipeline control unit: successor to the single-state reset/operate controller. Sequences boot after reset, selects the next-PC source from trap/jump/branch requests, and stretches the pipeline flush over a configurable depth. Also handles hazard stalls, halt/resume and a saturating redirect counter. Sits between the hazard/branch-resolution logic and the PC mux and pipeline-register flush inputs.

---
 rtl/pipe_ctrl_unit.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: boot sequencing, next-PC source selection, stretched flush,
// stall/halt handling and a saturating redirect counter.
module pipe_ctrl_unit #(
   parameter int unsigned BOOT_CYCLES = 2,
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             trap_in,
   input  logic             jump_in,
   input  logic             branch_taken_in,
   input  logic             stall_in,
   input  logic             halt_in,
   input  logic             resume_in,
   output logic             flush_out,
   output logic [1:0]       pc_src_out,
   output logic             pc_we_out,
   output logic [2:0]       state_out,
   output logic [CNT_W-1:0] redirect_cnt_out
);

   localparam int unsigned CtrMax = (BOOT_CYCLES > FLUSH_DEPTH) ? BOOT_CYCLES : FLUSH_DEPTH;
   localparam int unsigned CtrW   = $clog2(CtrMax + 2);

   localparam logic [CtrW-1:0] BootLoad  = (BOOT_CYCLES > 0) ? CtrW'(BOOT_CYCLES - 1) : '0;
   localparam logic [CtrW-1:0] FlushLoad = (FLUSH_DEPTH > 1) ? CtrW'(FLUSH_DEPTH - 2) : '0;

   localparam logic [1:0] SrcVec    = 2'b00;
   localparam logic [1:0] SrcBranch = 2'b01;
   localparam logic [1:0] SrcJump   = 2'b10;
   localparam logic [1:0] SrcSeq    = 2'b11;

   typedef enum logic [2:0] {
      StReset = 3'd0,
      StBoot  = 3'd1,
      StRun   = 3'd2,
      StFlush = 3'd3,
      StHalt  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [CtrW-1:0]   ctr_q, ctr_d;
   logic [CNT_W-1:0]  rcnt_q, rcnt_d;
   logic              redirect;

   assign redirect = trap_in | jump_in | branch_taken_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= StReset;
         ctr_q   <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         rcnt_q  <= rcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      rcnt_d  = rcnt_q;
      unique case (state_q)
         StReset: begin
            if (BOOT_CYCLES == 0) begin
               state_d = StRun;
            end else begin
               state_d = StBoot;
               ctr_d   = BootLoad;
            end
         end
         StBoot: begin
            if (ctr_q == '0) state_d = StRun;
            else             ctr_d   = ctr_q - CtrW'(1);
         end
         StRun: begin
            if (redirect) begin
               if (rcnt_q != '1) rcnt_d = rcnt_q + CNT_W'(1);
               // A single-cycle flush needs no FLUSH state at all
               if (FLUSH_DEPTH > 1) begin
                  state_d = StFlush;
                  ctr_d   = FlushLoad;
               end
            end else if (halt_in) begin
               state_d = StHalt;
            end
         end
         StFlush: begin
            if (ctr_q == '0) state_d = StRun;
            else             ctr_d   = ctr_q - CtrW'(1);
         end
         StHalt: begin
            if (resume_in) state_d = StRun;
         end
         default: begin
            state_d = StReset;
            ctr_d   = '0;
         end
      endcase
   end

   always_comb begin
      flush_out  = 1'b1;
      pc_src_out = SrcVec;
      pc_we_out  = 1'b0;
      unique case (state_q)
         StBoot: begin
            pc_we_out = 1'b1;
         end
         StRun: begin
            if (trap_in) begin
               pc_we_out = 1'b1;
            end else if (jump_in) begin
               pc_src_out = SrcJump;
               pc_we_out  = 1'b1;
            end else if (branch_taken_in) begin
               pc_src_out = SrcBranch;
               pc_we_out  = 1'b1;
            end else begin
               flush_out  = 1'b0;
               pc_src_out = SrcSeq;
               pc_we_out  = !(halt_in | stall_in);
            end
         end
         StFlush: begin
            pc_src_out = SrcSeq;
            pc_we_out  = !stall_in;
         end
         StHalt: begin
            flush_out  = 1'b0;
            pc_src_out = SrcSeq;
         end
         default: begin
            flush_out  = 1'b1;
            pc_src_out = SrcVec;
            pc_we_out  = 1'b0;
         end
      endcase
   end

   assign state_out        = state_q;
   assign redirect_cnt_out = rcnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two configurations driven in lockstep, directed vector table,
// hand-written corner sequences and randomized traffic against an abstract reference model.
module tb_pipe_ctrl_unit;

   logic clk;
   logic rst_n, trap, jump, br, stall, halt, resume;

   logic       a_flush, a_we, b_flush, b_we;
   logic [1:0] a_src, b_src;
   logic [2:0] a_state, b_state;
   logic [7:0] a_cnt;
   logic [1:0] b_cnt;

   pipe_ctrl_unit #(.BOOT_CYCLES(2), .FLUSH_DEPTH(3), .CNT_W(8)) dut_a (
      .clk_in(clk), .rst_n_in(rst_n), .trap_in(trap), .jump_in(jump),
      .branch_taken_in(br), .stall_in(stall), .halt_in(halt), .resume_in(resume),
      .flush_out(a_flush), .pc_src_out(a_src), .pc_we_out(a_we), .state_out(a_state),
      .redirect_cnt_out(a_cnt)
   );

   pipe_ctrl_unit #(.BOOT_CYCLES(0), .FLUSH_DEPTH(1), .CNT_W(2)) dut_b (
      .clk_in(clk), .rst_n_in(rst_n), .trap_in(trap), .jump_in(jump),
      .branch_taken_in(br), .stall_in(stall), .halt_in(halt), .resume_in(resume),
      .flush_out(b_flush), .pc_src_out(b_src), .pc_we_out(b_we), .state_out(b_state),
      .redirect_cnt_out(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phases tracked as remaining-cycle counts rather than states
   typedef struct {
      bit in_reset;
      int boot_left;
      int flush_left;
      bit halted;
      int cnt;
   } m_t;

   m_t m[2];
   int boot_cfg[2] = '{2, 0};
   int fd_cfg[2]   = '{3, 1};
   int cmax_cfg[2] = '{255, 3};

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m[i].in_reset = 1; m[i].boot_left = 0; m[i].flush_left = 0;
         m[i].halted = 0; m[i].cnt = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (m[i].in_reset) begin
            m[i].in_reset = 0;
            m[i].boot_left = boot_cfg[i];
         end else if (m[i].boot_left > 0) begin
            m[i].boot_left--;
         end else if (m[i].flush_left > 0) begin
            m[i].flush_left--;
         end else if (m[i].halted) begin
            if (resume) m[i].halted = 0;
         end else if (trap | jump | br) begin
            if (m[i].cnt < cmax_cfg[i]) m[i].cnt++;
            m[i].flush_left = fd_cfg[i] - 1;
         end else if (halt) begin
            m[i].halted = 1;
         end
      end
   endtask

   function automatic void exp_out(input int i, output int st, output int fl,
                                   output int src, output int we);
      if (m[i].in_reset) begin
         st = 0; fl = 1; src = 0; we = 0;
      end else if (m[i].boot_left > 0) begin
         st = 1; fl = 1; src = 0; we = 1;
      end else if (m[i].flush_left > 0) begin
         st = 3; fl = 1; src = 3; we = stall ? 0 : 1;
      end else if (m[i].halted) begin
         st = 4; fl = 0; src = 3; we = 0;
      end else begin
         st = 2;
         if (trap)      begin fl = 1; src = 0; we = 1; end
         else if (jump) begin fl = 1; src = 2; we = 1; end
         else if (br)   begin fl = 1; src = 1; we = 1; end
         else           begin fl = 0; src = 3; we = (halt | stall) ? 0 : 1; end
      end
   endfunction

   task automatic check_models();
      int st, fl, src, we;
      exp_out(0, st, fl, src, we);
      chk("a_state", 32'(a_state), 32'(st));
      chk("a_flush", 32'(a_flush), 32'(fl));
      chk("a_src", 32'(a_src), 32'(src));
      chk("a_we", 32'(a_we), 32'(we));
      chk("a_cnt", 32'(a_cnt), 32'(m[0].cnt));
      exp_out(1, st, fl, src, we);
      chk("b_state", 32'(b_state), 32'(st));
      chk("b_flush", 32'(b_flush), 32'(fl));
      chk("b_src", 32'(b_src), 32'(src));
      chk("b_we", 32'(b_we), 32'(we));
      chk("b_cnt", 32'(b_cnt), 32'(m[1].cnt));
   endtask

   task automatic drive(input bit r, input bit t, input bit j, input bit b,
                        input bit s, input bit h, input bit rs);
      @(negedge clk);
      rst_n = r; trap = t; jump = j; br = b; stall = s; halt = h; resume = rs;
      if (!r) model_reset();
      #1;
      check_models();
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
   endtask

   typedef struct {
      bit t, j, b, s, h, rs;
      int st, fl, src, we, cnt;
   } vec_t;

   vec_t tbl[20];
   int   sat_exp[5] = '{1, 2, 3, 3, 3};

   initial begin
      // Directed vectors for dut_a (BOOT_CYCLES=2, FLUSH_DEPTH=3), one cycle per entry
      tbl[0]  = '{0,0,0,0,0,0, 0,1,0,0,0};
      tbl[1]  = '{0,0,0,0,0,0, 1,1,0,1,0};
      tbl[2]  = '{1,0,0,0,0,0, 1,1,0,1,0};
      tbl[3]  = '{0,0,0,0,0,0, 2,0,3,1,0};
      tbl[4]  = '{0,1,1,1,0,0, 2,1,2,1,0};
      tbl[5]  = '{1,0,0,0,0,0, 3,1,3,1,1};
      tbl[6]  = '{0,0,0,1,1,0, 3,1,3,0,1};
      tbl[7]  = '{0,0,0,0,0,0, 2,0,3,1,1};
      tbl[8]  = '{0,0,0,1,0,0, 2,0,3,0,1};
      tbl[9]  = '{0,0,0,1,0,0, 2,0,3,0,1};
      tbl[10] = '{0,0,0,1,0,0, 2,0,3,0,1};
      tbl[11] = '{0,0,0,1,0,0, 2,0,3,0,1};
      tbl[12] = '{0,0,0,0,1,0, 2,0,3,0,1};
      tbl[13] = '{1,0,0,1,0,0, 4,0,3,0,1};
      tbl[14] = '{0,0,0,0,1,1, 4,0,3,0,1};
      tbl[15] = '{1,0,0,0,0,0, 2,1,0,1,1};
      tbl[16] = '{0,0,0,0,0,0, 3,1,3,1,2};
      tbl[17] = '{0,0,0,0,0,0, 3,1,3,1,2};
      tbl[18] = '{0,0,1,0,0,0, 2,1,1,1,2};
      tbl[19] = '{0,0,0,0,0,0, 3,1,3,1,3};

      rst_n = 0; trap = 0; jump = 0; br = 0; stall = 0; halt = 0; resume = 0;
      model_reset();
      #1;
      chk("rst_state", 32'(a_state), 32'd0);
      chk("rst_flush", 32'(a_flush), 32'd1);
      chk("rst_we", 32'(a_we), 32'd0);
      chk("rst_src", 32'(a_src), 32'd0);
      drive(0, 0,0,0,0,0,0); tick();
      drive(0, 1,1,1,1,1,1); tick();

      for (int k = 0; k < 20; k++) begin
         drive(1, tbl[k].t, tbl[k].j, tbl[k].b, tbl[k].s, tbl[k].h, tbl[k].rs);
         chk($sformatf("vec%0d_state", k), 32'(a_state), 32'(tbl[k].st));
         chk($sformatf("vec%0d_flush", k), 32'(a_flush), 32'(tbl[k].fl));
         chk($sformatf("vec%0d_src", k), 32'(a_src), 32'(tbl[k].src));
         chk($sformatf("vec%0d_we", k), 32'(a_we), 32'(tbl[k].we));
         chk($sformatf("vec%0d_cnt", k), 32'(a_cnt), 32'(tbl[k].cnt));
         tick();
      end

      // Async reset between edges while dut_a is mid-FLUSH
      #2;
      rst_n = 0;
      model_reset();
      #1;
      chk("arst_state", 32'(a_state), 32'd0);
      chk("arst_flush", 32'(a_flush), 32'd1);
      chk("arst_src", 32'(a_src), 32'd0);
      chk("arst_cnt", 32'(a_cnt), 32'd0);
      check_models();

      // Saturation on dut_b (CNT_W=2, FLUSH_DEPTH=1)
      drive(0, 0,0,0,0,0,0); tick();
      for (int k = 0; k < 3; k++) begin
         drive(1, 0,0,0,0,0,0); tick();
      end
      for (int k = 0; k < 5; k++) begin
         drive(1, 0,0,1,0,0,0);
         chk($sformatf("sat%0d_flush", k), 32'(b_flush), 32'd1);
         chk($sformatf("sat%0d_src", k), 32'(b_src), 32'd1);
         tick();
         #1;
         chk($sformatf("sat%0d_cnt", k), 32'(b_cnt), 32'(sat_exp[k]));
         chk($sformatf("sat%0d_state", k), 32'(b_state), 32'd2);
      end

      for (int k = 0; k < 3000; k++) begin
         drive($urandom_range(0, 99) != 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0,  $urandom_range(0, 3) == 0,
               $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
